bcd_serial_adder_ctrl: RTL and testbench
========================================

BCD_SERIAL_ADDER_CTRL -- requirements
Module: bcd_serial_adder_ctrl

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 Port: b  input  4*DIGITS  operand B, same packing.
REQ-008 Port: cin  input  1  decimal carry-in to digit 0.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: sum  output  4*DIGITS  packed BCD result.
REQ-012 Port: cout  output  1  decimal carry out of the top digit.
REQ-013 Port: err  output  1  at least one operand digit was greater than 9.
REQ-014 Port: busy  output  1  high in ADD state.

Function
REQ-015 FSM states SHALL be IDLE, ADD, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; when in_valid=1, capture a, b and cin, clear digit index and sum register, then go to ADD.
REQ-017 ADD: one digit per cycle through a single shared digit adder; in_ready=0; in_valid ignored.
REQ-018 Digit rule: t = a_d + b_d + carry (5-bit).
  - t > 9: digit = (t + 6) mod 16, carry = 1.
  - Otherwise: digit = t, carry = 0.
REQ-019 Each ADD cycle SHALL write the digit into sum at the current index, update carry, and increment the index.
REQ-020 After the digit at index DIGITS-1 is processed, the FSM SHALL go to DONE and cout SHALL equal the final carry.
REQ-021 Latency: if the input handshake occurs at edge T, out_valid SHALL be 1 after edge T+DIGITS.
REQ-022 DONE: out_valid=1; sum, cout and err held stable until out_ready=1.
  - Handshake edge: go to IDLE.
  - The next operands are accepted no earlier than the following edge (no back-to-back in DONE).
REQ-023 err SHALL be set during ADD if any processed a_d or b_d exceeds 9, and SHALL stay set through DONE.
  - err is cleared on the next input acceptance.
  - The sum is still produced by REQ-018.
REQ-024 sum, cout and err SHALL change only in ADD or at input acceptance, never in DONE.
REQ-025 Changing a, b or cin after acceptance SHALL NOT affect the result in flight.
REQ-026 out_ready while not in DONE SHALL be ignored.
REQ-027 Digit index wrap: the index SHALL NOT exceed DIGITS-1, and no write outside sum SHALL occur.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, err=0, index=0, carry=0.
REQ-029 Reset asserted mid-ADD or in DONE SHALL abort the operation with no result handshake; normal operation resumes on the first edge after rst_n=1.

Verification (DIGITS=4)
REQ-030 a=0x1234, b=0x8766, cin=0 -> after 4 cycles out_valid=1, sum=0x0000, cout=1, err=0.
REQ-031 a=0x9999, b=0x0000, cin=1 -> sum=0x0000, cout=1; separately, a=0x0456, b=0x0544, cin=0 -> sum=0x1000, cout=0.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout held, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-033 Invalid digit: a=0x000A, b=0x0001, cin=0 -> err=1, sum=0x0011, cout=0; the next valid operation shows err=0.
REQ-034 Reset asserted at ADD cycle 2 -> outputs at reset values immediately; a fresh 0x0001+0x0001 then yields sum=0x0002 in 4 cycles.
REQ-035 Operand change after acceptance: a/b toggled every cycle during ADD -> result matches the captured operands.

Source files
------------

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: captures two operands, adds one decimal digit per
// cycle through a single shared digit adder, and holds the result until it is consumed.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err,
    output logic                  busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] a_q, a_d;
    logic [4*DIGITS-1:0] b_q, b_d;
    logic [4*DIGITS-1:0] sum_q, sum_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                err_q, err_d;

    logic [3:0]          a_dig, b_dig, s_dig;
    logic                s_carry;

    // Decimal digit add with +6 correction; returns {carry, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       c);
        logic [4:0] t;
        logic [4:0] adj;
        t   = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        adj = t + 5'd6;
        if (t > 5'd9) begin
            return {1'b1, adj[3:0]};
        end
        return {1'b0, t[3:0]};
    endfunction

    // Operand digit selection only ever matches an in-range index.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        {s_carry, s_dig} = bcd_digit_add(a_dig, b_dig, carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = s_dig;
                    end
                end
                carry_d = s_carry;
                if ((a_dig > 4'd9) || (b_dig > 4'd9)) begin
                    err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    cout_d  = s_carry;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Captured operands are only read in ADD, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed and random bench for bcd_serial_adder_ctrl (DIGITS=4) with a result scoreboard.
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_miss;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: digit-by-digit decimal addition, subtracting ten on overflow.
    function automatic exp_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t r;
        int   s;
        int   cy;
        r  = '0;
        cy = int'(c);
        for (int d = 0; d < DIGITS; d++) begin
            s = int'(x[4*d +: 4]) + int'(y[4*d +: 4]) + cy;
            if (x[4*d +: 4] > 4'd9 || y[4*d +: 4] > 4'd9) r.err = 1'b1;
            if (s >= 10) begin
                r.sum[4*d +: 4] = 4'((s - 10) & 15);
                cy = 1;
            end else begin
                r.sum[4*d +: 4] = 4'(s);
                cy = 0;
            end
        end
        r.cout = cy[0];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                          input exp_t e, input int hold, input bit tgl);
        exp_t got;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        a        = ai;
        b        = bi;
        cin      = ci;
        in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = tgl;
        for (int k = 1; k < DIGITS; k++) begin
            chk("add_out_valid", 32'(out_valid), 32'd0);
            chk("add_busy", 32'(busy), 32'd1);
            chk("add_in_ready", 32'(in_ready), 32'd0);
            out_ready = 1'b1;
            if (tgl) begin
                a   = ~a;
                b   = b ^ 16'h5A5A;
                cin = ~cin;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("sum", 32'(sum), 32'(got.sum));
            chk("cout", 32'(cout), 32'(got.cout));
            chk("err", 32'(err), 32'(got.err));
        end
        in_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_sum", 32'(sum), 32'(e.sum));
            chk("hold_cout", 32'(cout), 32'(e.cout));
            chk("hold_err", 32'(err), 32'(e.err));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic e);
        exp_t r;
        r.sum  = s;
        r.cout = c;
        r.err  = e;
        return r;
    endfunction

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h8766, 1'b0, mk(16'h0000, 1'b1, 1'b0), 0, 1'b0);
        run_op(16'h9999, 16'h0000, 1'b1, mk(16'h0000, 1'b1, 1'b0), 0, 1'b0);
        run_op(16'h0456, 16'h0544, 1'b0, mk(16'h1000, 1'b0, 1'b0), 1, 1'b0);
        run_op(16'h2500, 16'h2500, 1'b0, mk(16'h5000, 1'b0, 1'b0), 5, 1'b0);
        run_op(16'h000A, 16'h0001, 1'b0, mk(16'h0011, 1'b0, 1'b1), 2, 1'b0);
        run_op(16'h0001, 16'h0002, 1'b0, mk(16'h0003, 1'b0, 1'b0), 0, 1'b0);

        // Abort an operation partway through ADD.
        @(negedge clk);
        a        = 16'h4444;
        b        = 16'h5555;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, mk(16'h0002, 1'b0, 1'b0), 0, 1'b0);

        run_op(16'h5678, 16'h4321, 1'b1, mk(16'h0000, 1'b1, 1'b0), 0, 1'b1);

        for (int n = 0; n < 6; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, ref_add(ra, rb, rc), n % 3, n[0]);
        end
        for (int n = 0; n < 3; n++) begin
            ra = 16'($urandom());
            rb = 16'($urandom());
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, ref_add(ra, rb, rc), 1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
